// File: rtl/tt_uart_pkg.sv
// Shared UART definitions: frame state encoding and line levels.
// Used by both the transmitter and the matching receiver.
package tt_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Wide enough to index up to 8 data bits.
  localparam int unsigned BIT_IDX_W = 3;

endpackage

// File: rtl/tt_baud_gen.sv
// Bit-period timer: a down-counter that flags the last cycle of each serial bit.
// It reloads on restart and after every bit end, so consecutive bits need no extra control.
module tt_baud_gen #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

  logic [15:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || cnt == 16'd0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

  assign bit_end = (cnt == 16'd0);

endmodule

// File: rtl/tt_uart_tx.sv
// UART transmitter: valid/ready word input, start + LSB-first data + optional
// even parity + stop bit on a single line. All outputs are registered.
module tt_uart_tx
  import tt_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shift;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic                 parity;
  logic                 accept;
  logic                 bit_end;

  // NOTE: continuous assign rather than an incomplete always block, so no latch can be inferred.
  assign accept = (state == IDLE) && in_valid && in_ready;

  tt_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .bit_end (bit_end)
  );

  // Outputs are loaded with the level of the state being entered, so tx
  // changes on the same edge as the state and never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= LINE_IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      shift    <= '0;
      bit_idx  <= '0;
      parity   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx       <= LINE_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          if (accept) begin
            state    <= START;
            tx       <= START_BIT;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            shift    <= in_data;
            bit_idx  <= '0;
            parity   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            parity <= parity ^ shift[0];
            shift  <= shift >> 1;
            if (bit_idx == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= parity ^ shift[0];
              end else begin
                state <= STOP;
                tx    <= LINE_IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= LINE_IDLE;
          end
        end
        STOP: begin
          if (bit_end) begin
            state    <= IDLE;
            tx       <= LINE_IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            bit_idx  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= LINE_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
